// File: rtl/bubble_exec_sequencer.sv
// bubble_exec_sequencer
//   Multi-cycle control sequencer in front of a combinational ALU. Each
//   instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK (4 cycles
//   minimum, plus one cycle per instruction-memory wait state). The
//   sequencer stops in HALT when it decodes HALT_OPCODE.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   run                 : level enable, sampled in IDLE and at end of WRITEBACK
//   imem_req/addr       : fetch request and word address (= pc)
//   imem_ack/rdata      : fetch completion and instruction word
//   rf_rs/rt_addr/data  : two combinational register-file read ports
//   alu_*  (outputs)    : instruction fields, operands and pc for the ALU
//   alu_dest/pc_new     : ALU result and next-pc
//   rf_we/wr_addr/data  : register-file write port (one-cycle pulse)
//   busy/halted/retired : status and completed-instruction count
module bubble_exec_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_rs_addr,
    output logic [4:0]  rf_rt_addr,
    input  logic [31:0] rf_rs_data,
    input  logic [31:0] rf_rt_data,
    output logic [5:0]  alu_opcode,
    output logic [4:0]  alu_funct,
    output logic [4:0]  alu_shamt,
    output logic [31:0] alu_s1,
    output logic [31:0] alu_s2,
    output logic [15:0] alu_pc,
    output logic [15:0] alu_const,
    output logic [25:0] alu_jump_addr,
    input  logic [31:0] alu_dest,
    input  logic [15:0] alu_pc_new,
    output logic        rf_we,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        busy,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_t;

    state_t      state, state_next;
    logic [31:0] ir;
    logic [15:0] pc;
    logic [31:0] dest_q;
    logic [15:0] pc_new_q;
    logic [5:0]  opcode;
    logic        writes_reg;
    logic        takes_branch;
    logic [4:0]  wr_sel;

    // Instruction fields come straight from IR so the ALU sees them stable
    // from DECODE through WRITEBACK.
    assign opcode        = ir[31:26];
    assign alu_opcode    = opcode;
    assign alu_funct     = ir[4:0];
    assign alu_shamt     = ir[10:6];
    assign alu_const     = ir[15:0];
    assign alu_jump_addr = ir[25:0];
    assign alu_pc        = pc;
    assign imem_addr     = pc;
    assign rf_rs_addr    = ir[25:21];
    assign rf_rt_addr    = ir[20:16];

    // R-type writes rd, I-type ALU ops (1..6) write rt, branches/jumps
    // (7..15) redirect the pc.
    always_comb begin
        writes_reg   = (opcode <= 6'd6);
        takes_branch = (opcode >= 6'd7) && (opcode <= 6'd15);
        wr_sel       = (opcode == 6'd0) ? ir[15:11] : ir[20:16];
    end

    assign rf_wr_addr = wr_sel;
    assign rf_wr_data = dest_q;
    // r0 is hard-wired zero, so writes to it never reach the register file.
    assign rf_we      = (state == S_WRITEBACK) && writes_reg && (wr_sel != 5'd0);
    assign imem_req   = (state == S_FETCH);
    assign busy       = (state != S_IDLE) && (state != S_HALT);
    assign halted     = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (run) state_next = S_FETCH;
            S_FETCH:     if (imem_ack) state_next = S_DECODE;
            S_DECODE:    state_next = (opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = run ? S_FETCH : S_IDLE;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= '0;
            pc       <= RESET_PC;
            alu_s1   <= '0;
            alu_s2   <= '0;
            dest_q   <= '0;
            pc_new_q <= '0;
            retired  <= '0;
        end else begin
            case (state)
                S_FETCH: if (imem_ack) ir <= imem_rdata;
                S_DECODE: begin
                    alu_s1 <= rf_rs_data;
                    alu_s2 <= rf_rt_data;
                end
                S_EXECUTE: begin
                    dest_q   <= alu_dest;
                    pc_new_q <= alu_pc_new;
                end
                S_WRITEBACK: begin
                    // 16-bit pc and 32-bit counter wrap naturally.
                    pc      <= takes_branch ? pc_new_q : pc + 16'd1;
                    retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_exec_sequencer.sv
module tb_bubble_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst, run;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_rs_addr, rf_rt_addr;
    logic [31:0] rf_rs_data, rf_rt_data;
    logic [5:0]  alu_opcode;
    logic [4:0]  alu_funct, alu_shamt;
    logic [31:0] alu_s1, alu_s2;
    logic [15:0] alu_pc, alu_const;
    logic [25:0] alu_jump_addr;
    logic [31:0] alu_dest;
    logic [15:0] alu_pc_new;
    logic        rf_we;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        busy, halted;
    logic [31:0] retired;

    bubble_exec_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_shamt(alu_shamt),
        .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_pc(alu_pc), .alu_const(alu_const),
        .alu_jump_addr(alu_jump_addr), .alu_dest(alu_dest), .alu_pc_new(alu_pc_new),
        .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Register file model (combinational read)
    logic [31:0] regs [32];
    assign rf_rs_data = regs[rf_rs_addr];
    assign rf_rt_data = regs[rf_rt_addr];

    // Instruction memory responder: ack after ack_delay wait cycles
    logic [31:0] instr_word = '0;
    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_rdata = instr_word;
            if (imem_req === 1'b1) begin
                imem_ack = (wait_cnt >= ack_delay);
                wait_cnt++;
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard of expected register writes {addr, data}
    logic [36:0] sb_q[$];
    logic        prev_we = 1'b0;
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL rf_write_unexpected: got addr=%0d data=%0d, required no write", rf_wr_addr, rf_wr_data);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                if ({rf_wr_addr, rf_wr_data} !== e) begin
                    bad++;
                    $display("FAIL rf_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             rf_wr_addr, rf_wr_data, e[36:32], e[31:0]);
                end
            end
            if (prev_we === 1'b1) begin
                total++; bad++;
                $display("FAIL rf_we_pulse: got 2 consecutive cycles, required 1");
            end
        end
        prev_we = rf_we;
    end

    // Expected architectural state
    logic [15:0] exp_pc      = 16'd0;
    logic [31:0] exp_retired = 32'd0;

    // Snapshot of ALU-facing outputs taken during the (last) EXECUTE cycle
    logic [31:0] snap_s1, snap_s2;
    logic [4:0]  snap_funct;
    logic [15:0] snap_const, snap_pc;
    logic [25:0] snap_jump;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh, fn);
        return {op, rs, rt, rd, sh, 1'b0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Runs `count` copies of instr back to back; run is dropped during the
    // last instruction's EXECUTE cycle. cycles = busy cycles observed.
    task automatic exec(input logic [31:0] instr, input int delay, input logic [31:0] dest,
                        input logic [15:0] pcnew, input int count, output int cycles);
        logic [5:0]  op;
        logic [15:0] start_pc;
        bit          done;
        int          drop_at;
        op = instr[31:26];
        start_pc = exp_pc;
        instr_word = instr; ack_delay = delay; alu_dest = dest; alu_pc_new = pcnew;
        for (int k = 0; k < count; k++) begin
            if (op == 6'd0 && instr[15:11] != 5'd0) sb_q.push_back({instr[15:11], dest});
            else if (op >= 6'd1 && op <= 6'd6 && instr[20:16] != 5'd0) sb_q.push_back({instr[20:16], dest});
            if (op != 6'd63) begin
                exp_retired = exp_retired + 32'd1;
                exp_pc = (op >= 6'd7 && op <= 6'd15) ? pcnew : exp_pc + 16'd1;
            end
        end
        drop_at = (count - 1) * (delay + 4) + delay + 3;
        @(negedge clk); run = 1'b1;
        @(posedge clk);
        cycles = 0; done = 0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cycles++;
                if (cycles == 1) begin
                    total++;
                    if (imem_req !== 1'b1 || imem_addr !== start_pc) begin
                        bad++;
                        $display("FAIL fetch_addr: got req=%0b addr=%0d, required req=1 addr=%0d", imem_req, imem_addr, start_pc);
                    end
                end
                if (cycles == drop_at) begin
                    snap_s1 = alu_s1; snap_s2 = alu_s2; snap_funct = alu_funct;
                    snap_const = alu_const; snap_jump = alu_jump_addr; snap_pc = alu_pc;
                    run = 1'b0;
                end
            end else done = 1;
        end
        run = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL timeout: busy still high after %0d cycles, required to finish", cycles);
        end
    endtask

    task automatic check_arch(input string name);
        total++;
        if (imem_addr !== exp_pc || retired !== exp_retired || sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_state: got pc=%0d retired=%0d pending=%0d, required pc=%0d retired=%0d pending=0",
                     name, imem_addr, retired, sb_q.size(), exp_pc, exp_retired);
        end
    endtask

    task automatic test_reset();
        ack_delay = 10;
        @(negedge clk); run = 1'b1;
        @(negedge clk); @(negedge clk);
        total++;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_pre_req: got %0b, required 1", imem_req); end
        #1 rst = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 16'd0 || retired !== 32'd0 || busy !== 1'b0 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got req=%0b pc=%0d retired=%0d busy=%0b we=%0b, required all 0",
                     imem_req, imem_addr, retired, busy, rf_we);
        end
        run = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%0b req=%0b halted=%0b, required 0/0/0", busy, imem_req, halted);
        end
        exp_pc = 16'd0; exp_retired = 32'd0;
    endtask

    task automatic test_rtype();
        int cyc;
        exec(enc_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1), 0, 32'd100, 16'h0, 1, cyc);
        total++;
        if (snap_s1 !== 32'd123 || snap_s2 !== 32'd23 || snap_funct !== 5'd1) begin
            bad++;
            $display("FAIL rtype_operands: got s1=%0d s2=%0d funct=%0d, required 123/23/1", snap_s1, snap_s2, snap_funct);
        end
        total++;
        if (cyc != 4) begin bad++; $display("FAIL rtype_latency: got %0d cycles, required 4", cyc); end
        check_arch("rtype");
    endtask

    task automatic test_branch();
        int cyc;
        exec(enc_i(6'd7, 5'd1, 5'd2, 16'd1000), 0, 32'hDEAD, 16'd1001, 1, cyc);
        total++;
        if (snap_const !== 16'd1000 || snap_pc !== 16'd1) begin
            bad++;
            $display("FAIL branch_fields: got const=%0d pc=%0d, required 1000/1", snap_const, snap_pc);
        end
        check_arch("branch");
    endtask

    task automatic test_jump_wait();
        int cyc;
        exec({6'd13, 26'd512}, 3, 32'd0, 16'd512, 1, cyc);
        total++;
        if (snap_jump !== 26'd512) begin bad++; $display("FAIL jump_addr: got %0d, required 512", snap_jump); end
        total++;
        if (cyc != 7) begin bad++; $display("FAIL jump_latency: got %0d cycles, required 7", cyc); end
        check_arch("jump");
    endtask

    task automatic test_r0_guard();
        int cyc;
        exec(enc_r(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 5'd1), 1, 32'd55, 16'h0, 1, cyc);
        check_arch("r0_guard");
    endtask

    task automatic test_wrap();
        int cyc;
        exec(enc_i(6'd9, 5'd0, 5'd0, 16'hFFFF), 0, 32'd0, 16'hFFFF, 1, cyc);
        check_arch("to_ffff");
        exec(enc_i(6'd1, 5'd1, 5'd5, 16'd7), 0, 32'd77, 16'h1234, 1, cyc);
        check_arch("wrap");
        total++;
        if (imem_addr !== 16'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_idle: got pc=%0d busy=%0b, required 0/0", imem_addr, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        exec(enc_r(6'd0, 5'd2, 5'd1, 5'd9, 5'd3, 5'd4), 0, 32'hCAFE_F00D, 16'h0, 2, cyc);
        total++;
        if (cyc != 8) begin bad++; $display("FAIL b2b_latency: got %0d cycles, required 8", cyc); end
        total++;
        if (snap_s1 !== 32'd23 || snap_s2 !== 32'd123) begin
            bad++;
            $display("FAIL b2b_operands: got s1=%0d s2=%0d, required 23/123", snap_s1, snap_s2);
        end
        check_arch("b2b");
    endtask

    task automatic test_halt();
        int cyc;
        int reqs;
        exec({6'd63, 26'd0}, 0, 32'd1, 16'd1, 1, cyc);
        total++;
        if (halted !== 1'b1 || busy !== 1'b0 || cyc != 2) begin
            bad++;
            $display("FAIL halt_state: got halted=%0b busy=%0b cycles=%0d, required 1/0/2", halted, busy, cyc);
        end
        run = 1'b1;
        reqs = 0;
        repeat (5) begin @(negedge clk); if (imem_req === 1'b1) reqs++; end
        run = 1'b0;
        total++;
        if (reqs != 0) begin bad++; $display("FAIL halt_no_fetch: got %0d req cycles, required 0", reqs); end
        check_arch("halt");
        #1 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_pc = 16'd0; exp_retired = 32'd0;
        total++;
        if (halted !== 1'b0 || busy !== 1'b0 || imem_addr !== 16'd0 || retired !== 32'd0) begin
            bad++;
            $display("FAIL halt_reset: got halted=%0b busy=%0b pc=%0d retired=%0d, required 0/0/0/0",
                     halted, busy, imem_addr, retired);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd123;
        regs[2] = 32'd23;
        alu_dest = '0; alu_pc_new = '0;
        rst = 1'b1; run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_rtype();
        test_branch();
        test_jump_wait();
        test_r0_guard();
        test_wrap();
        test_back_to_back();
        test_halt();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
